// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the MCP4921-class DAC serialiser.
package dac_spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int SAMPLE_W = 12;
  localparam int CFG_W    = FRAME_W - SAMPLE_W;

  // Config nibble fields, frame bits [15:12] from MSB down.
  localparam logic CFG_AB     = 1'b0;  // 0 = channel A
  localparam logic CFG_BUF    = 1'b0;  // 0 = VREF input unbuffered
  localparam logic CFG_GA_N   = 1'b1;  // 1 = gain 1x
  localparam logic CFG_SHDN_N = 1'b1;  // 1 = output active

  localparam logic [CFG_W-1:0] CFG_BITS_DEFAULT = {CFG_AB, CFG_BUF, CFG_GA_N, CFG_SHDN_N};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CS_HOLD = 2'd2,
    ST_LDAC    = 2'd3
  } dac_state_t;

  // Assemble one DAC frame: config nibble followed by the sample, MSB first.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [CFG_W-1:0]    cfg,
                                                     input logic [SAMPLE_W-1:0] sample);
    return {cfg, sample};
  endfunction

endpackage

// File: rtl/dac_spi_if.sv
// Sample hand-off between the mixer and the DAC serialiser.
interface dac_spi_if;
  import dac_spi_pkg::*;

  logic [SAMPLE_W-1:0] i_sample;
  logic                i_sample_valid;
  logic                o_busy;
  logic                o_overrun;

  modport master (output i_sample, output i_sample_valid, input o_busy, input o_overrun);
  modport slave  (input i_sample, input i_sample_valid, output o_busy, output o_overrun);

endinterface

// File: rtl/dac_sck_tick.sv
// Loadable down-counter producing a one-cycle tick every CLK_DIV enabled cycles.
module dac_sck_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_phase_done
);

  localparam int               CNT_W  = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done       = i_en && (r_cnt == '0);
  assign o_phase_done = w_done;

  // Count down each enabled cycle; reload on a new frame or at every phase boundary.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
    end else if (i_load || w_done) begin
      r_cnt <= RELOAD;
    end else if (i_en) begin
      r_cnt <= r_cnt - ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 12-bit mixer samples into 16-bit SPI frames for an MCP4921-class DAC,
// with a one-deep pending slot and a trailing LDAC pulse per frame.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int               CLK_DIV  = 4,
  parameter logic [CFG_W-1:0] CFG_BITS = CFG_BITS_DEFAULT
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  dac_spi_if.slave  io_bus,
  output logic      o_dac_cs_n,
  output logic      o_dac_sck,
  output logic      o_dac_sdi,
  output logic      o_dac_ldac_n
);

  dac_state_t          r_state, w_state_nxt;
  logic [FRAME_W-1:0]  r_shreg, w_shreg_nxt;
  logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic                r_pend_valid, w_pend_valid_nxt;
  logic [SAMPLE_W-1:0] r_pend_data, w_pend_data_nxt;
  logic                r_cs_n, w_cs_n_nxt;
  logic                r_sck, w_sck_nxt;
  logic                r_ldac_n, w_ldac_n_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic                w_load;
  logic                w_tick_en;
  logic                w_phase_done;

  assign w_tick_en = (r_state != ST_IDLE);

  dac_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_load),
    .i_en         (w_tick_en),
    .o_phase_done (w_phase_done)
  );

  // Next-state, shift, pending-slot and pin decisions for the frame sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_data_nxt  = r_pend_data;
    w_cs_n_nxt       = r_cs_n;
    w_sck_nxt        = r_sck;
    w_ldac_n_nxt     = r_ldac_n;
    w_overrun_nxt    = 1'b0;
    w_load           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A fresh strobe wins over the pending slot, which is then dropped.
        if (io_bus.i_sample_valid) begin
          w_load           = 1'b1;
          w_shreg_nxt      = build_frame(CFG_BITS, io_bus.i_sample);
          w_overrun_nxt    = r_pend_valid;
          w_pend_valid_nxt = 1'b0;
        end else if (r_pend_valid) begin
          w_load           = 1'b1;
          w_shreg_nxt      = build_frame(CFG_BITS, r_pend_data);
          w_pend_valid_nxt = 1'b0;
        end else begin
          w_load           = 1'b0;
        end
        if (w_load) begin
          w_state_nxt   = ST_SHIFT;
          w_cs_n_nxt    = 1'b0;
          w_sck_nxt     = 1'b0;
          w_bit_cnt_nxt = 4'd0;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (w_phase_done) begin
          if (!r_sck) begin
            w_sck_nxt = 1'b1;
          end else begin
            // Falling edge: present the next bit; after the last bit the register drains to zero.
            w_sck_nxt   = 1'b0;
            w_shreg_nxt = {r_shreg[FRAME_W-2:0], 1'b0};
            if (r_bit_cnt == 4'd15) begin
              w_state_nxt = ST_CS_HOLD;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end else begin
          w_sck_nxt = r_sck;
        end
      end

      ST_CS_HOLD: begin
        if (w_phase_done) begin
          w_state_nxt  = ST_LDAC;
          w_cs_n_nxt   = 1'b1;
          w_ldac_n_nxt = 1'b0;
        end else begin
          w_state_nxt  = ST_CS_HOLD;
        end
      end

      ST_LDAC: begin
        if (w_phase_done) begin
          w_state_nxt  = ST_IDLE;
          w_ldac_n_nxt = 1'b1;
        end else begin
          w_state_nxt  = ST_LDAC;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_cs_n_nxt   = 1'b1;
        w_sck_nxt    = 1'b0;
        w_ldac_n_nxt = 1'b1;
      end
    endcase

    // Strobes that arrive mid-frame park in the pending slot; the newest one wins.
    if ((r_state != ST_IDLE) && io_bus.i_sample_valid) begin
      w_pend_valid_nxt = 1'b1;
      w_pend_data_nxt  = io_bus.i_sample;
      w_overrun_nxt    = r_pend_valid;
    end else begin
      w_pend_data_nxt  = w_pend_data_nxt;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Register the sequencer state and every pin so outputs are glitch-free.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= 4'd0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_cs_n       <= 1'b1;
      r_sck        <= 1'b0;
      r_ldac_n     <= 1'b1;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_data  <= w_pend_data_nxt;
      r_cs_n       <= w_cs_n_nxt;
      r_sck        <= w_sck_nxt;
      r_ldac_n     <= w_ldac_n_nxt;
      r_busy       <= w_busy_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign o_dac_cs_n       = r_cs_n;
  assign o_dac_sck        = r_sck;
  assign o_dac_sdi        = r_shreg[FRAME_W-1];
  assign o_dac_ldac_n     = r_ldac_n;
  assign io_bus.o_busy    = r_busy;
  assign io_bus.o_overrun = r_overrun;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: DUT a runs CLK_DIV=2, DUT b runs CLK_DIV=1.
// Frames are rebuilt from the SPI pins and checked against a scoreboard queue.
module tb_dac_spi_tx;
  import dac_spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b;
  logic cs_a, sck_a, sdi_a, ldac_a;
  logic cs_b, sck_b, sdi_b, ldac_b;

  dac_spi_if bus_a ();
  dac_spi_if bus_b ();

  dac_spi_tx #(.CLK_DIV(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n_a), .io_bus(bus_a),
    .o_dac_cs_n(cs_a), .o_dac_sck(sck_a), .o_dac_sdi(sdi_a), .o_dac_ldac_n(ldac_a)
  );

  dac_spi_tx #(.CLK_DIV(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n_b), .io_bus(bus_b),
    .o_dac_cs_n(cs_b), .o_dac_sck(sck_b), .o_dac_sdi(sdi_b), .o_dac_ldac_n(ldac_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  bit mon_on = 1'b0;

  logic        prev_cs [2];
  logic        prev_sck [2];
  logic        prev_ldac [2];
  logic        prev_busy [2];
  logic [15:0] acc [2];
  int          nbits [2];
  int          ldac_falls [2];
  int          ovr_cnt [2];
  int          busy_run [2];
  int          frames [2];

  logic [15:0] q_a [$];
  logic [15:0] q_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rebuild frames from the pins of DUT k and score them.
  task automatic mon(input int k, input logic cs_n, input logic sck, input logic sdi,
                     input logic ldac_n, input logic busy, input logic ovr,
                     input logic rst_n, input int div);
    logic [15:0] e;
    if (!rst_n) begin
      nbits[k]    = 0;
      busy_run[k] = 0;
    end else begin
      if (prev_cs[k] && !cs_n) begin
        acc[k]   = 16'h0000;
        nbits[k] = 0;
      end
      if (!prev_sck[k] && sck) begin
        acc[k]   = {acc[k][14:0], sdi};
        nbits[k] = nbits[k] + 1;
      end
      if (!prev_cs[k] && cs_n) begin
        frames[k] = frames[k] + 1;
        chk("bit_count", nbits[k], 32'd16);
        if (k == 0) begin
          chk("sb_has_exp_a", 32'(q_a.size() > 0), 32'd1);
          if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("frame_a", acc[k], e);
          end
        end else begin
          chk("sb_has_exp_b", 32'(q_b.size() > 0), 32'd1);
          if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("frame_b", acc[k], e);
          end
        end
      end
      if (prev_ldac[k] && !ldac_n) ldac_falls[k] = ldac_falls[k] + 1;
      if (ovr) ovr_cnt[k] = ovr_cnt[k] + 1;
      if (busy) begin
        busy_run[k] = busy_run[k] + 1;
      end else if (prev_busy[k]) begin
        chk("busy_len", busy_run[k], 32'(34 * div));
        busy_run[k] = 0;
      end
    end
    prev_cs[k]   = cs_n;
    prev_sck[k]  = sck;
    prev_ldac[k] = ldac_n;
    prev_busy[k] = busy;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (mon_on) begin
      mon(0, cs_a, sck_a, sdi_a, ldac_a, bus_a.o_busy, bus_a.o_overrun, rst_n_a, 2);
      mon(1, cs_b, sck_b, sdi_b, ldac_b, bus_b.o_busy, bus_b.o_overrun, rst_n_b, 1);
    end
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - t0) < n) cycle();
  endtask

  task automatic strobe_a(input logic [11:0] s);
    bus_a.i_sample = s;
    bus_a.i_sample_valid = 1'b1;
    cycle();
    bus_a.i_sample_valid = 1'b0;
  endtask

  task automatic strobe_b(input logic [11:0] s);
    bus_b.i_sample = s;
    bus_b.i_sample_valid = 1'b1;
    cycle();
    bus_b.i_sample_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int base_ovr;
    int base_ldac;
    int base_frames;
    logic [15:0] dropped;

    for (int k = 0; k < 2; k++) begin
      acc[k] = 16'h0000; nbits[k] = 0; ldac_falls[k] = 0;
      ovr_cnt[k] = 0; busy_run[k] = 0; frames[k] = 0;
    end
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    bus_a.i_sample = 12'h000; bus_a.i_sample_valid = 1'b0;
    bus_b.i_sample = 12'h000; bus_b.i_sample_valid = 1'b0;

    // Reset held for three cycles, then 100 quiet cycles.
    repeat (3) cycle();
    chk("reset_a", {cs_a, sck_a, sdi_a, ldac_a, bus_a.o_busy, bus_a.o_overrun}, 32'b100100);
    chk("reset_b", {cs_b, sck_b, sdi_b, ldac_b, bus_b.o_busy, bus_b.o_overrun}, 32'b100100);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    for (int k = 0; k < 2; k++) begin
      prev_cs[k] = 1'b1; prev_sck[k] = 1'b0; prev_ldac[k] = 1'b1; prev_busy[k] = 1'b0;
    end
    mon_on = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if ({cs_a, sck_a, ldac_a, bus_a.o_busy, bus_a.o_overrun} !== 5'b10100) bad++;
      if ({cs_b, sck_b, ldac_b, bus_b.o_busy, bus_b.o_overrun} !== 5'b10100) bad++;
    end
    chk("idle_100", bad, 32'd0);

    // Single frame at CLK_DIV=2 with exact pin timing.
    q_a.push_back(16'h3A5C);
    t0 = cyc;
    strobe_a(12'hA5C);
    chk("c1_cs_low", {cs_a, sck_a, sdi_a, bus_a.o_busy}, 32'b0001);
    wait_rel(2);  chk("c2_sck_low", sck_a, 32'd0);
    wait_rel(3);  chk("c3_first_rise", sck_a, 32'd1);
    wait_rel(9);  chk("c9_sdi_bit13", sdi_a, 32'd1);
    wait_rel(66); chk("c66_cs_ldac", {cs_a, ldac_a}, 32'b01);
    wait_rel(67); chk("c67_cs_up_ldac", {cs_a, ldac_a, bus_a.o_busy}, 32'b101);
    wait_rel(68); chk("c68_ldac_busy", {ldac_a, bus_a.o_busy}, 32'b01);
    wait_rel(69); chk("c69_idle", {ldac_a, bus_a.o_busy}, 32'b10);
    wait_rel(80);

    // Extremes at CLK_DIV=1: 000 then FFF, second waits in the pending slot.
    q_b.push_back(16'h3000);
    q_b.push_back(16'h3FFF);
    t0 = cyc;
    strobe_b(12'h000);
    wait_rel(4);
    strobe_b(12'hFFF);
    wait_rel(34); chk("ext_busy_34", bus_b.o_busy, 32'd1);
    wait_rel(35); chk("ext_gap_35", {cs_b, bus_b.o_busy}, 32'b10);
    wait_rel(36); chk("ext_relaunch_36", {cs_b, bus_b.o_busy}, 32'b01);
    wait_rel(80);

    // Pending and overrun: 222 is overwritten by 333.
    base_ovr = ovr_cnt[0];
    q_a.push_back(16'h3111);
    t0 = cyc;
    strobe_a(12'h111);
    wait_rel(10);
    q_a.push_back(16'h3222);
    strobe_a(12'h222);
    chk("ovr_on_222", bus_a.o_overrun, 32'd0);
    wait_rel(20);
    strobe_a(12'h333);
    chk("ovr_on_333", bus_a.o_overrun, 32'd1);
    dropped = q_a.pop_back();
    q_a.push_back(16'h3333);
    wait_rel(150);
    chk("ovr_pulses", ovr_cnt[0] - base_ovr, 32'd1);
    chk("q_a_drained", q_a.size(), 32'd0);

    // Reset at bit 7 with a sample pending; a strobe during reset is ignored.
    base_ldac = ldac_falls[0];
    base_frames = frames[0];
    t0 = cyc;
    strobe_a(12'h5A5);
    wait_rel(8);
    strobe_a(12'h1A1);
    wait_rel(30);
    rst_n_a = 1'b0;
    strobe_a(12'h7E7);
    chk("rst_mid_a", {cs_a, sck_a, sdi_a, ldac_a, bus_a.o_busy, bus_a.o_overrun}, 32'b100100);
    rst_n_a = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if ({cs_a, ldac_a, bus_a.o_busy} !== 3'b110) bad++;
    end
    chk("post_rst_quiet", bad, 32'd0);
    chk("post_rst_no_ldac", ldac_falls[0] - base_ldac, 32'd0);
    chk("post_rst_no_frame", frames[0] - base_frames, 32'd0);

    // Strobe on the launch-eligible IDLE cycle while the slot is full.
    base_ovr = ovr_cnt[1];
    q_b.push_back(16'h3ABC);
    t0 = cyc;
    strobe_b(12'hABC);
    wait_rel(5);
    q_b.push_back(16'h3444);
    strobe_b(12'h444);
    wait_rel(35);
    chk("elig_idle", bus_b.o_busy, 32'd0);
    strobe_b(12'hDEF);
    chk("elig_ovr", bus_b.o_overrun, 32'd1);
    dropped = q_b.pop_back();
    q_b.push_back(16'h3DEF);
    wait_rel(90);
    chk("elig_ovr_pulses", ovr_cnt[1] - base_ovr, 32'd1);
    chk("q_b_drained", q_b.size(), 32'd0);
    chk("dropped_was_444", dropped, 32'h3444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Consumer end of the mixer's 12-bit output. Takes a 12-bit mixed sample on a single-cycle strobe and serialises it to an external 12-bit SPI DAC (MCP4921-class). Frame is 16 bits: 4 config bits, then 12 data bits.
- Owns the chip-select, serial clock, data and LDAC pins, so one sample becomes one DAC update.
- Sits between the mixer and the FPGA I/O pins.

Parameters:
- CLK_DIV, 4, i_clk cycles per SCK half-period; legal range 1..255.
- CFG_BITS, 4'b0011, frame bits [15:12]: channel A, unbuffered, gain 1x, active.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  reset: synchronous, active-low.
- i_sample  in  12  unsigned mixed sample.
- i_sample_valid  in  1  single-cycle strobe; i_sample is captured on this cycle.
- o_busy  out  1  high while a frame or LDAC pulse is in progress.
- o_overrun  out  1  one-cycle pulse when a pending sample is overwritten.
- o_dac_cs_n  out  1  chip select, active-low.
- o_dac_sck  out  1  serial clock, idle low; data sampled by the DAC on the rising edge.
- o_dac_sdi  out  1  serial data, MSB first.
- o_dac_ldac_n  out  1  latch-DAC strobe, active-low.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - o_dac_cs_n=1, o_dac_sck=0, o_dac_sdi=0, o_dac_ldac_n=1, o_busy=0, o_overrun=0.
  - Pending slot cleared; state goes to IDLE.
  - Reset mid-frame aborts the frame immediately; the sample is lost.
- All outputs are registered. There is no input backpressure.
- States: IDLE, SHIFT, CS_HOLD, LDAC.
- IDLE:
  - Launch condition: i_sample_valid or the pending slot is full.
  - On launch, load the 16-bit shift register with {CFG_BITS, sample}. A new strobe takes priority over the pending slot.
  - If both a strobe and a full pending slot are present, the pending sample is discarded and o_overrun pulses.
  - Launch cycle = cycle 0. Next state is SHIFT.
- SHIFT:
  - Starts at cycle 1 with o_dac_cs_n=0, o_dac_sdi=bit15, o_dac_sck=0.
  - Each of the 16 bits has CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - At the end of a high phase, SCK falls and SDI advances to the next bit in the same cycle.
  - The first SCK rising edge is at cycle 1+CLK_DIV.
  - After the 16th high phase, SCK goes low and the state moves to CS_HOLD.
  - SHIFT lasts 32*CLK_DIV cycles.
- CS_HOLD: CLK_DIV cycles with CS low and SCK low. Then CS rises and the state moves to LDAC.
- LDAC: CLK_DIV cycles with o_dac_ldac_n=0 and CS high. Then go to IDLE with LDAC high.
- Frame timing:
  - o_busy is high from cycle 1 through cycle 34*CLK_DIV.
  - Back in IDLE at cycle 1+34*CLK_DIV.
  - Back-to-back frames are separated by at least one IDLE cycle.
- Strobe while not in IDLE (including the final LDAC cycle): the sample goes into the one-deep pending slot.
  - If the slot is already full, the newest sample overwrites it and o_overrun pulses for 1 cycle.
- The in-flight frame is never altered by new strobes.
- A strobe in the same cycle as reset is ignored.
- Division counter width: $clog2(CLK_DIV+1). The counter is reloaded on every phase change.

Decomposition:
- Shared package dac_spi_pkg:
  - State enum (IDLE, SHIFT, CS_HOLD, LDAC).
  - FRAME_W=16, SAMPLE_W=12.
  - CFG_BITS default constants (channel select, buffer, gain, shutdown bit positions).
- One natural sub-module, dac_sck_tick: a loadable down-counter that emits a one-cycle phase_done tick every CLK_DIV cycles while enabled.
  - The FSM owns the shift register, bit counter (0..15) and pending slot.

Test Plan:
- Reset then idle: hold i_rst_n low for 3 cycles, release, no strobe for 100 cycles -> cs_n=1, sck=0, ldac_n=1, busy=0, overrun=0 throughout.
- Single frame, CLK_DIV=2, sample 12'hA5C at cycle 0:
  - CS falls at cycle 1; 16 SCK rising edges, first at cycle 3.
  - Bits sampled on the rising edges = 16'h3A5C.
  - CS rises at cycle 67; LDAC low for cycles 67-68; busy falls at cycle 69.
- Extremes, CLK_DIV=1: samples 12'h000 then 12'hFFF -> frames 16'h3000 and 16'h3FFF, each 34 cycles long, with an IDLE gap of at least 1 cycle.
- Pending/overrun: strobe 12'h111, then 12'h222 and 12'h333 during that frame:
  - Exactly one o_overrun pulse, on the 12'h333 strobe.
  - Second frame carries 16'h3333; 12'h222 is never sent.
- Reset mid-frame: assert i_rst_n low at bit 7 of SHIFT -> the next cycle shows all reset values, no LDAC pulse, pending cleared.
- Strobe on the launch-eligible IDLE cycle with pending full: frame carries the new strobe's sample, o_overrun pulses once.
